oob_device_control: RTL and testbench
=====================================

OOB_DEVICE_CONTROL -- requirements
Module: oob_device_control

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Parameter TIMEOUT SHALL default to 18'h203AD and SHALL set the wait-state timeout in clk cycles (about 880 us).
REQ-003 Parameter GAP SHALL default to 6'h3F and SHALL set the post-COMWAKE quiet count.
REQ-004 Ports SHALL be exactly the following; all are 1 bit unless a width is given:
- clk  in  -- transceiver user clock; all logic on rising edge
- reset  in  -- asynchronous active-low reset (0 = reset)
- rx_locked  in  -- GTX PLL locked
- gen2  in  -- 3 Gb/s when 1, 1.5 Gb/s when 0
- cominitdet  in  -- GTX OOB detector: host COMRESET seen
- comwakedet  in  -- GTX OOB detector: host COMWAKE seen
- rxelecidle  in  -- RX electrical idle
- rxbyteisaligned  in  -- RX comma alignment done
- rx_datain  in  32 -- received dword
- rx_charisk_in  in  4 -- received K flags
- tx_datain  in  32 -- link-layer TX dword
- tx_charisk_in  in  -- link-layer K flag for byte 0
- txcominit  out  -- request the GTX to send COMINIT
- txcomwake  out  -- request the GTX to send COMWAKE
- txelecidle_out  out  -- TX electrical idle
- tx_dataout  out  32 -- dword to GTX
- tx_charisk_out  out  -- byte-0 K flag to GTX
- rx_dataout  out  32 -- dword to link layer
- rx_charisk_out  out  4 -- K flags to link layer
- linkup  out  -- link established
- align_en_out  out  -- ALIGN insertion active; link layer pauses
- state_out  out  4 -- current state code

Function
REQ-005 The block SHALL register all RX-side inputs once; every decision below SHALL use these registered copies.
REQ-006 Primitives SHALL be ALIGN 32'h7B4A4ABC, SYNC 32'hB5B5957C and D10.2 32'h4A4A4A4A; align_det SHALL be ALIGN received while rxbyteisaligned is 1.
REQ-007 An 18-bit counter SHALL increment while the state requests counting and SHALL clear to 0 on every state transition.
REQ-008 The state machine SHALL have the following states, codes and transitions:
- WAIT_COMRESET (0): go to COMRESET_GAP (1) on cominitdet when rx_locked=1
- COMRESET_GAP (1): go to SEND_COMINIT (2) when rxelecidle=1 and count=GAP
- SEND_COMINIT (2): hold txcominit=1 until count = 18'h51 (gen1) or 18'hA2 (gen2), then go to WAIT_COMWAKE (3)
- WAIT_COMWAKE (3): go to SEND_COMWAKE (4) on comwakedet; at count=TIMEOUT go back to SEND_COMINIT
- SEND_COMWAKE (4): hold txcomwake=1 until count = 18'h4E (gen1) or 18'h9B (gen2), then go to COMWAKE_GAP (5)
- COMWAKE_GAP (5): go to SEND_ALIGN (6) at count=GAP
- SEND_ALIGN (6): set txelecidle to 0 and transmit ALIGN with K=1; go to SEND_SYNC (7) on align_det; at count=TIMEOUT go to WAIT_COMRESET
- SEND_SYNC (7): transmit SYNC with K=1; go to LINK_READY (8) after 3 consecutive non-ALIGN dwords with rxelecidle=0; any ALIGN restarts the run of 3
- LINK_READY (8): pass tx_datain and tx_charisk_in through, except while align_en=1, when ALIGN with K=1 is sent instead
REQ-009 txelecidle_out SHALL be 1 in states 0-5 and 0 in states 6-8.
REQ-010 In states 6 and 7, rx_dataout SHALL equal the registered rx_datain and rx_charisk_out SHALL be 0.
REQ-011 In state 8 with rxelecidle=0, rx_dataout and rx_charisk_out SHALL pass the registered inputs; in all other cases both SHALL be 0.
REQ-012 linkup SHALL be 1 exactly when the state is 8 and rxelecidle is 0.
REQ-013 In state 8, an 8-bit align counter SHALL run freely and SHALL wrap from 255 to 0.
REQ-014 align_en SHALL be 1 at align counter values 0 and 1, which gives 2 ALIGNs per 256 dwords.
REQ-015 align_en_out SHALL be 0 outside state 8.
REQ-016 The align counter SHALL clear to 0 on entry to state 8, so the first two link dwords are ALIGN.
REQ-017 tx_dataout and tx_charisk_out SHALL be registered outputs that reflect the state and data selected in the previous cycle.
REQ-018 In states 0-5, tx_dataout SHALL be D10.2 and tx_charisk_out SHALL be 0.
REQ-019 cominitdet SHALL take priority in every state except 0 and force the state to COMRESET_GAP (1); linkup SHALL drop in the same cycle as the state change.
REQ-020 rx_locked=0 in any state SHALL force WAIT_COMRESET (0) on the next cycle.
REQ-021 If comwakedet and count=TIMEOUT occur together in state 3, comwakedet SHALL win.
REQ-022 If align_det and count=TIMEOUT occur together in state 6, align_det SHALL win.

Reset
REQ-023 While reset=0, the state SHALL be 0 and both counters SHALL be 0.
REQ-024 While reset=0: txelecidle_out=1; txcominit, txcomwake, linkup, align_en_out and tx_charisk_out = 0; tx_dataout, rx_dataout and rx_charisk_out = 0.
REQ-025 Reset asserted mid-operation SHALL take effect immediately without waiting for a clock edge.
REQ-026 After reset release, the block SHALL resume at WAIT_COMRESET.

Verification
REQ-027 Full gen1 bring-up SHALL pass: COMRESET, then COMWAKE, then host ALIGN, then host SYNC -> txcominit high for 0x51+1 cycles, txcomwake high for 0x4E+1 cycles, SYNC sent after align_det, linkup=1 three cycles after the first non-ALIGN dword.
REQ-028 Gen2 timing SHALL pass: gen2=1 -> COMINIT 0xA2+1 cycles and COMWAKE 0x9B+1 cycles.
REQ-029 COMWAKE timeout SHALL be covered: no comwakedet -> return to state 2 at count 0x203AD and COMINIT re-issued (TIMEOUT may be overridden to 0x1FF in simulation).
REQ-030 Link-state ALIGN insertion SHALL be covered: in state 8 with tx_datain=0x12345678 -> exactly 2 ALIGN dwords, then 254 passthrough dwords, repeating; align_en_out high for exactly those 2 dwords.
REQ-031 COMRESET while linked SHALL be covered: cominitdet pulse -> state 1 next cycle, linkup=0, txelecidle_out=1.
REQ-032 Asynchronous reset SHALL be covered: reset=0 asserted while in state 7 -> all outputs at reset values without any clock edge.

Source files
------------

// File: rtl/oob_device_control.sv
// Device-side SATA OOB sequencer for a GTX transceiver: COMRESET/COMINIT and
// COMWAKE handshake, ALIGN/SYNC bring-up, then periodic ALIGN insertion on a live link.
module oob_device_control #(
    parameter logic [17:0] TIMEOUT = 18'h203AD,
    parameter logic [5:0]  GAP     = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_locked,
    input  logic        gen2,
    input  logic        cominitdet,
    input  logic        comwakedet,
    input  logic        rxelecidle,
    input  logic        rxbyteisaligned,
    input  logic [31:0] rx_datain,
    input  logic [3:0]  rx_charisk_in,
    input  logic [31:0] tx_datain,
    input  logic        tx_charisk_in,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle_out,
    output logic [31:0] tx_dataout,
    output logic        tx_charisk_out,
    output logic [31:0] rx_dataout,
    output logic [3:0]  rx_charisk_out,
    output logic        linkup,
    output logic        align_en_out,
    output logic [3:0]  state_out
);

    localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_P  = 32'hB5B5957C;
    localparam logic [31:0] D102_P  = 32'h4A4A4A4A;

    typedef enum logic [3:0] {
        WAIT_COMRESET = 4'd0,
        COMRESET_GAP  = 4'd1,
        SEND_COMINIT  = 4'd2,
        WAIT_COMWAKE  = 4'd3,
        SEND_COMWAKE  = 4'd4,
        COMWAKE_GAP   = 4'd5,
        SEND_ALIGN    = 4'd6,
        SEND_SYNC     = 4'd7,
        LINK_READY    = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] count_q, count_d;
    logic [1:0]  run_q, run_d;
    logic [7:0]  acnt_q, acnt_d;

    logic        cominit_q, comwake_q, elecidle_q, aligned_q;
    logic [31:0] rx_data_q;
    logic [3:0]  rx_k_q;

    logic        txcominit_q, txcomwake_q, txelecidle_q, linkup_q, align_en_q;
    logic [31:0] tx_data_q;
    logic        tx_k_q;

    logic        align_det, is_align, force_init, count_en;
    logic [17:0] cominit_len, comwake_len, gap_ext;

    assign is_align    = (rx_data_q == ALIGN_P);
    assign align_det   = is_align && aligned_q;
    assign force_init  = rx_locked && cominit_q && (state_q != WAIT_COMRESET);
    assign cominit_len = gen2 ? 18'hA2 : 18'h51;
    assign comwake_len = gen2 ? 18'h9B : 18'h4E;
    assign gap_ext     = {12'd0, GAP};

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        count_en = 1'b0;
        if (!rx_locked) begin
            state_d = WAIT_COMRESET;
        end else if (force_init) begin
            state_d = COMRESET_GAP;
        end else begin
            unique case (state_q)
                WAIT_COMRESET: if (cominit_q) state_d = COMRESET_GAP;
                COMRESET_GAP: begin
                    // Quiet period only advances while the line is actually idle.
                    count_en = elecidle_q;
                    if (elecidle_q && count_q == gap_ext) state_d = SEND_COMINIT;
                end
                SEND_COMINIT: begin
                    count_en = 1'b1;
                    if (count_q == cominit_len) state_d = WAIT_COMWAKE;
                end
                WAIT_COMWAKE: begin
                    count_en = 1'b1;
                    if (comwake_q)                state_d = SEND_COMWAKE;
                    else if (count_q == TIMEOUT)  state_d = SEND_COMINIT;
                end
                SEND_COMWAKE: begin
                    count_en = 1'b1;
                    if (count_q == comwake_len) state_d = COMWAKE_GAP;
                end
                COMWAKE_GAP: begin
                    count_en = 1'b1;
                    if (count_q == gap_ext) state_d = SEND_ALIGN;
                end
                SEND_ALIGN: begin
                    count_en = 1'b1;
                    if (align_det)                state_d = SEND_SYNC;
                    else if (count_q == TIMEOUT)  state_d = WAIT_COMRESET;
                end
                SEND_SYNC: begin
                    // Need three back-to-back non-ALIGN dwords on an active line.
                    if (is_align || elecidle_q) run_d = 2'd0;
                    else if (run_q == 2'd2)     state_d = LINK_READY;
                    else                        run_d = run_q + 2'd1;
                end
                LINK_READY: ;
                default: state_d = WAIT_COMRESET;
            endcase
        end

        if (state_d != state_q || force_init) begin
            count_d = 18'd0;
            run_d   = 2'd0;
        end else if (count_en) begin
            count_d = count_q + 18'd1;
        end else begin
            count_d = count_q;
        end

        acnt_d = (state_q == LINK_READY && state_d == LINK_READY) ? acnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_COMRESET;
            count_q      <= '0;
            run_q        <= '0;
            acnt_q       <= '0;
            cominit_q    <= 1'b0;
            comwake_q    <= 1'b0;
            elecidle_q   <= 1'b0;
            aligned_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_k_q       <= '0;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            txelecidle_q <= 1'b1;
            linkup_q     <= 1'b0;
            align_en_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_k_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            run_q        <= run_d;
            acnt_q       <= acnt_d;
            cominit_q    <= cominitdet;
            comwake_q    <= comwakedet;
            elecidle_q   <= rxelecidle;
            aligned_q    <= rxbyteisaligned;
            rx_data_q    <= rx_datain;
            rx_k_q       <= rx_charisk_in;
            txcominit_q  <= (state_d == SEND_COMINIT);
            txcomwake_q  <= (state_d == SEND_COMWAKE);
            txelecidle_q <= !(state_d inside {SEND_ALIGN, SEND_SYNC, LINK_READY});
            linkup_q     <= (state_d == LINK_READY) && !rxelecidle;
            align_en_q   <= (state_d == LINK_READY) && (acnt_d < 8'd2);
            // TX word follows the state and link data of the cycle just ending.
            unique case (state_q)
                SEND_ALIGN: begin tx_data_q <= ALIGN_P; tx_k_q <= 1'b1; end
                SEND_SYNC:  begin tx_data_q <= SYNC_P;  tx_k_q <= 1'b1; end
                LINK_READY: begin
                    tx_data_q <= align_en_q ? ALIGN_P : tx_datain;
                    tx_k_q    <= align_en_q ? 1'b1    : tx_charisk_in;
                end
                default:    begin tx_data_q <= D102_P;  tx_k_q <= 1'b0; end
            endcase
        end
    end

    logic rx_pass;
    assign rx_pass = (state_q == LINK_READY) && !elecidle_q;

    assign rx_dataout     = (rx_pass || state_q == SEND_ALIGN || state_q == SEND_SYNC) ? rx_data_q : '0;
    assign rx_charisk_out = rx_pass ? rx_k_q : '0;
    assign txcominit      = txcominit_q;
    assign txcomwake      = txcomwake_q;
    assign txelecidle_out = txelecidle_q;
    assign linkup         = linkup_q;
    assign align_en_out   = align_en_q;
    assign tx_dataout     = tx_data_q;
    assign tx_charisk_out = tx_k_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_oob_device_control.sv
// Directed bench for oob_device_control: gen1/gen2 bring-up, timeouts, link ALIGN
// insertion, COMRESET while linked, PLL loss and asynchronous reset.
module tb_oob_device_control;

    localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_P  = 32'hB5B5957C;
    localparam logic [31:0] D102_P  = 32'h4A4A4A4A;
    localparam logic [31:0] LINK_D  = 32'h12345678;

    logic        clk = 1'b0;
    logic        reset, rx_locked, gen2, cominitdet, comwakedet, rxelecidle, rxbyteisaligned;
    logic [31:0] rx_datain, tx_datain;
    logic [3:0]  rx_charisk_in;
    logic        tx_charisk_in;
    logic        txcominit, txcomwake, txelecidle_out, tx_charisk_out, linkup, align_en_out;
    logic [31:0] tx_dataout, rx_dataout;
    logic [3:0]  rx_charisk_out, state_out;

    always #5 clk = ~clk;

    oob_device_control #(.TIMEOUT(18'h1FF)) dut (
        .clk(clk), .reset(reset), .rx_locked(rx_locked), .gen2(gen2),
        .cominitdet(cominitdet), .comwakedet(comwakedet), .rxelecidle(rxelecidle),
        .rxbyteisaligned(rxbyteisaligned), .rx_datain(rx_datain), .rx_charisk_in(rx_charisk_in),
        .tx_datain(tx_datain), .tx_charisk_in(tx_charisk_in), .txcominit(txcominit),
        .txcomwake(txcomwake), .txelecidle_out(txelecidle_out), .tx_dataout(tx_dataout),
        .tx_charisk_out(tx_charisk_out), .rx_dataout(rx_dataout), .rx_charisk_out(rx_charisk_out),
        .linkup(linkup), .align_en_out(align_en_out), .state_out(state_out)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        idle;
        logic [31:0] rx_d;
        logic [3:0]  rx_k;
        logic [31:0] tx_d;
        logic        tx_k;
        logic [31:0] exp_rx_d;
        logic [3:0]  exp_rx_k;
        logic        exp_link;
        logic [31:0] exp_tx_d;
        logic        exp_tx_k;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return txcominit;
            1:       return txcomwake;
            2:       return state_out == 4'd3;
            default: return state_out == 4'd6;
        endcase
    endfunction

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n = 0;
        while (state_out != s && n < budget) begin
            tick();
            n++;
        end
        check(name, {28'd0, state_out}, {28'd0, s});
    endtask

    task automatic wait_sig(input int sel, input int budget, input string name);
        int n = 0;
        while (!sig(sel) && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, sig(sel)}, 32'd1);
    endtask

    task automatic measure(input int sel, input int exp, input string name);
        int n = 0;
        while (sig(sel) && n < 4096) begin
            n++;
            tick();
        end
        check(name, n, exp);
    endtask

    task automatic pulse_cominit();
        cominitdet = 1'b1;
        tick();
        cominitdet = 1'b0;
    endtask

    task automatic pulse_comwake();
        comwakedet = 1'b1;
        tick();
        comwakedet = 1'b0;
    endtask

    task automatic sb_check(input int i);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb c%0d: expected queue empty", i);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("tx_data c%0d", i), tx_dataout, e[31:0]);
            check($sformatf("tx_k c%0d", i), {31'd0, tx_charisk_out}, {31'd0, e[32]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"},      {28'd0, state_out},      32'd0);
        check({tag, " txelecidle"}, {31'd0, txelecidle_out}, 32'd1);
        check({tag, " txcominit"},  {31'd0, txcominit},      32'd0);
        check({tag, " txcomwake"},  {31'd0, txcomwake},      32'd0);
        check({tag, " linkup"},     {31'd0, linkup},         32'd0);
        check({tag, " align_en"},   {31'd0, align_en_out},   32'd0);
        check({tag, " tx_k"},       {31'd0, tx_charisk_out}, 32'd0);
        check({tag, " tx_data"},    tx_dataout,              32'd0);
        check({tag, " rx_data"},    rx_dataout,              32'd0);
        check({tag, " rx_k"},       {28'd0, rx_charisk_out}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rx_locked = 1'b0; gen2 = 1'b0; cominitdet = 1'b0; comwakedet = 1'b0;
        rxelecidle = 1'b1; rxbyteisaligned = 1'b0;
        rx_datain = 32'h11223344; rx_charisk_in = 4'hF;
        tx_datain = LINK_D; tx_charisk_in = 1'b0;

        vecs[0] = '{1'b0, 32'hDEADBEEF, 4'h1, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 4'h1, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[1] = '{1'b0, 32'h00000000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'hF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{1'b1, 32'hA5A5A5A5, 4'h3, 32'h00000001, 1'b0, 32'h00000000, 4'h0, 1'b0, 32'h00000001, 1'b0};
        vecs[3] = '{1'b0, ALIGN_P,      4'h1, ALIGN_P,      1'b1, ALIGN_P,      4'h1, 1'b1, ALIGN_P,      1'b1};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h00000000, 4'h0, 1'b0, 32'h5A5A5A5A, 1'b1};
        vecs[5] = '{1'b0, 32'h13579BDF, 4'h4, 32'h2468ACE0, 1'b0, 32'h13579BDF, 4'h4, 1'b1, 32'h2468ACE0, 1'b0};

        #22;
        check_reset_outputs("por");

        @(negedge clk);
        reset = 1'b1;
        rx_locked = 1'b1;
        repeat (3) tick();
        check("idle state", {28'd0, state_out}, 32'd0);
        check("idle tx_data", tx_dataout, D102_P);
        check("idle tx_k", {31'd0, tx_charisk_out}, 32'd0);
        check("idle txelecidle", {31'd0, txelecidle_out}, 32'd1);

        // Gen1 bring-up
        pulse_cominit();
        wait_state(4'd1, 10, "g1 to gap");
        wait_state(4'd2, 200, "g1 to cominit");
        measure(0, 32'h52, "g1 cominit len");
        check("g1 after cominit", {28'd0, state_out}, 32'd3);
        pulse_comwake();
        wait_sig(1, 10, "g1 comwake start");
        measure(1, 32'h4F, "g1 comwake len");
        check("g1 after comwake", {28'd0, state_out}, 32'd5);
        wait_state(4'd6, 200, "g1 to send_align");
        check("s6 txelecidle", {31'd0, txelecidle_out}, 32'd0);
        check("s6 rx_data", rx_dataout, 32'h11223344);
        check("s6 rx_k", {28'd0, rx_charisk_out}, 32'd0);
        tick();
        check("s6 tx_data", tx_dataout, ALIGN_P);
        check("s6 tx_k", {31'd0, tx_charisk_out}, 32'd1);

        rx_datain = ALIGN_P; rx_charisk_in = 4'h1; rxbyteisaligned = 1'b1; rxelecidle = 1'b0;
        wait_state(4'd7, 5, "g1 to send_sync");
        tick();
        check("s7 tx_data", tx_dataout, SYNC_P);
        check("s7 tx_k", {31'd0, tx_charisk_out}, 32'd1);
        check("s7 rx_data", rx_dataout, ALIGN_P);
        check("s7 rx_k", {28'd0, rx_charisk_out}, 32'd0);

        // Two SYNCs, then an ALIGN that must restart the run of three
        rx_datain = SYNC_P;
        tick(); tick();
        rx_datain = ALIGN_P;
        tick();
        rx_datain = SYNC_P;
        repeat (3) tick();
        check("s7 run not done state", {28'd0, state_out}, 32'd7);
        check("s7 run not done linkup", {31'd0, linkup}, 32'd0);
        tick();
        check("linkup state", {28'd0, state_out}, 32'd8);
        check("linkup", {31'd0, linkup}, 32'd1);

        // Link-state ALIGN insertion over two full periods
        for (int i = 0; i < 512; i++) begin
            logic exp_en;
            exp_en = (i % 256) < 2;
            check($sformatf("align_en c%0d", i), {31'd0, align_en_out}, {31'd0, exp_en});
            if (i > 0) sb_check(i);
            exp_q.push_back(exp_en ? {1'b1, ALIGN_P} : {1'b0, LINK_D});
            tick();
        end
        sb_check(512);
        check("link held", {31'd0, linkup}, 32'd1);

        begin
            int n = 0;
            while (align_en_out && n < 10) begin
                tick();
                n++;
            end
            check("align window passed", {31'd0, align_en_out}, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            rxelecidle = vecs[i].idle; rx_datain = vecs[i].rx_d; rx_charisk_in = vecs[i].rx_k;
            tx_datain = vecs[i].tx_d; tx_charisk_in = vecs[i].tx_k;
            tick();
            check($sformatf("vec%0d rx_data", i), rx_dataout, vecs[i].exp_rx_d);
            check($sformatf("vec%0d rx_k", i), {28'd0, rx_charisk_out}, {28'd0, vecs[i].exp_rx_k});
            check($sformatf("vec%0d linkup", i), {31'd0, linkup}, {31'd0, vecs[i].exp_link});
            check($sformatf("vec%0d tx_data", i), tx_dataout, vecs[i].exp_tx_d);
            check($sformatf("vec%0d tx_k", i), {31'd0, tx_charisk_out}, {31'd0, vecs[i].exp_tx_k});
        end

        // COMRESET while linked
        cominitdet = 1'b1;
        tick();
        cominitdet = 1'b0;
        check("comreset reg state", {28'd0, state_out}, 32'd8);
        tick();
        check("comreset state", {28'd0, state_out}, 32'd1);
        check("comreset linkup", {31'd0, linkup}, 32'd0);
        check("comreset txelecidle", {31'd0, txelecidle_out}, 32'd1);

        // Gen2 timing, COMWAKE timeout and SEND_ALIGN timeout
        gen2 = 1'b1; rxelecidle = 1'b1; rx_datain = SYNC_P; rxbyteisaligned = 1'b0;
        wait_state(4'd2, 200, "g2 to cominit");
        measure(0, 32'hA3, "g2 cominit len");
        measure(2, 32'h200, "comwake timeout len");
        check("timeout back to cominit", {28'd0, state_out}, 32'd2);
        measure(0, 32'hA3, "g2 cominit reissue len");
        pulse_comwake();
        wait_sig(1, 10, "g2 comwake start");
        measure(1, 32'h9C, "g2 comwake len");
        wait_state(4'd6, 200, "g2 to send_align");
        measure(3, 32'h200, "align timeout len");
        check("align timeout state", {28'd0, state_out}, 32'd0);
        check("align timeout txelecidle", {31'd0, txelecidle_out}, 32'd1);

        // PLL loss
        gen2 = 1'b0;
        pulse_cominit();
        wait_state(4'd1, 10, "pll to gap");
        rx_locked = 1'b0;
        tick();
        check("pll loss state", {28'd0, state_out}, 32'd0);
        rx_locked = 1'b1;

        // Asynchronous reset from SEND_SYNC
        pulse_cominit();
        wait_state(4'd2, 300, "ar to cominit");
        wait_state(4'd3, 300, "ar to wait_comwake");
        pulse_comwake();
        wait_state(4'd6, 300, "ar to send_align");
        rx_datain = ALIGN_P; rxbyteisaligned = 1'b1;
        wait_state(4'd7, 10, "ar to send_sync");
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        check("post reset state", {28'd0, state_out}, 32'd0);
        check("post reset tx_data", tx_dataout, D102_P);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
